// File: rtl/gpr_pkg.sv
// Shared defaults, register word/address types and the popcount helper
// for the scoreboarded register file.
package gpr_pkg;

   localparam int GPR_WIDTH = 32;
   localparam int GPR_DEPTH = 16;
   localparam int GPR_NRD   = 2;
   localparam int GPR_NWR   = 2;
   localparam int GPR_AW    = $clog2(GPR_DEPTH);

   // Widest busy vector the popcount helper accepts; narrower vectors are zero-extended.
   localparam int POP_MAX   = 256;
   localparam int POP_W     = $clog2(POP_MAX) + 1;

   typedef logic [GPR_AW-1:0]    addr_t;
   typedef logic [GPR_WIDTH-1:0] word_t;

   function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX-1:0] v);
      logic [POP_W-1:0] n;
      n = '0;
      for (int i = 0; i < POP_MAX; i++) begin
         n = n + {{(POP_W-1){1'b0}}, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/gpr_file_sb_scoreboard.sv
// Per-register busy tracking: reservation accept, writeback release, flush
// and the registered busy count.
module gpr_scoreboard
   import gpr_pkg::*;
#(
   parameter int DEPTH    = GPR_DEPTH,
   parameter int NWR      = GPR_NWR,
   parameter int ZERO_REG = 0,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NWR-1:0]    i_wr_en,
   input  logic [NWR*AW-1:0] i_wr_addr,
   input  logic              i_rsv_en,
   input  logic [AW-1:0]     i_rsv_addr,
   input  logic              i_flush,
   output logic              o_rsv_ok,
   output logic [DEPTH-1:0]  o_busy,
   output logic [AW:0]       o_busy_cnt
);

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_next;
   logic [AW:0]      r_busy_cnt;

   // Busy is sampled pre-edge, so a same-cycle writeback does not free the slot yet.
   assign o_rsv_ok = i_rsv_en & ~i_flush & ~rst & ~r_busy[i_rsv_addr];

   always_comb begin
      w_busy_next = r_busy;
      for (int p = 0; p < NWR; p++) begin
         if (i_wr_en[p]) begin
            w_busy_next[i_wr_addr[p*AW +: AW]] = 1'b0;
         end
      end
      // A reservation outranks a same-cycle write: it belongs to the newer instruction.
      if (o_rsv_ok) begin
         w_busy_next[i_rsv_addr] = 1'b1;
      end
      if (i_flush) begin
         w_busy_next = '0;
      end
      if (ZERO_REG != 0) begin
         w_busy_next[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         r_busy     <= w_busy_next;
         r_busy_cnt <= (AW+1)'(popcount(POP_MAX'(w_busy_next)));
      end
   end

   assign o_busy     = r_busy;
   assign o_busy_cnt = r_busy_cnt;

endmodule

// File: rtl/gpr_file_sb.sv
// Multi-port register file with write-port priority, optional same-cycle
// bypass, optional hardwired-zero register and an attached scoreboard.
module gpr_file_sb
   import gpr_pkg::*;
#(
   parameter int WIDTH    = GPR_WIDTH,
   parameter int DEPTH    = GPR_DEPTH,
   parameter int NRD      = GPR_NRD,
   parameter int NWR      = GPR_NWR,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NRD*AW-1:0]    i_rd_addr,
   output logic [NRD*WIDTH-1:0] o_rd_data,
   output logic [NRD-1:0]       o_rd_busy,
   input  logic [NWR-1:0]       i_wr_en,
   input  logic [NWR*AW-1:0]    i_wr_addr,
   input  logic [NWR*WIDTH-1:0] i_wr_data,
   input  logic                 i_rsv_en,
   input  logic [AW-1:0]        i_rsv_addr,
   output logic                 o_rsv_ok,
   input  logic                 i_flush,
   output logic [AW:0]          o_busy_cnt
);

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0] w_busy;

   gpr_scoreboard #(
      .DEPTH    (DEPTH),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .i_wr_en    (i_wr_en),
      .i_wr_addr  (i_wr_addr),
      .i_rsv_en   (i_rsv_en),
      .i_rsv_addr (i_rsv_addr),
      .i_flush    (i_flush),
      .o_rsv_ok   (o_rsv_ok),
      .o_busy     (w_busy),
      .o_busy_cnt (o_busy_cnt)
   );

   // Later ports are applied last, so the highest port index wins on a collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < DEPTH; r++) begin
            r_regs[r] <= '0;
         end
      end else begin
         for (int p = 0; p < NWR; p++) begin
            if (i_wr_en[p] && !(ZERO_REG != 0 && i_wr_addr[p*AW +: AW] == '0)) begin
               r_regs[i_wr_addr[p*AW +: AW]] <= i_wr_data[p*WIDTH +: WIDTH];
            end
         end
      end
   end

   always_comb begin
      logic [AW-1:0]    w_addr;
      logic [WIDTH-1:0] w_data;
      logic             w_busy_rd;
      o_rd_data = '0;
      o_rd_busy = '0;
      w_addr    = '0;
      w_data    = '0;
      w_busy_rd = 1'b0;
      for (int i = 0; i < NRD; i++) begin
         w_addr    = i_rd_addr[i*AW +: AW];
         w_data    = r_regs[w_addr];
         w_busy_rd = w_busy[w_addr];
         if (BYPASS != 0) begin
            for (int p = 0; p < NWR; p++) begin
               if (i_wr_en[p] && i_wr_addr[p*AW +: AW] == w_addr) begin
                  w_data    = i_wr_data[p*WIDTH +: WIDTH];
                  w_busy_rd = 1'b0;
               end
            end
         end
         if (rst || (ZERO_REG != 0 && w_addr == '0)) begin
            w_data    = '0;
            w_busy_rd = 1'b0;
         end
         o_rd_data[i*WIDTH +: WIDTH] = w_data;
         o_rd_busy[i]                = w_busy_rd;
      end
   end

endmodule

// File: tb/tb_gpr_file_sb.sv
// Drives three register-file variants (bypass, no bypass, zero register)
// with shared stimulus and checks each against expected values.
module tb_gpr_file_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rd_addr;
   logic [1:0]  wr_en;
   logic [7:0]  wr_addr;
   logic [63:0] wr_data;
   logic        rsv_en;
   logic [3:0]  rsv_addr;
   logic        flush;

   logic [63:0] b_rd_data, n_rd_data, z_rd_data;
   logic [1:0]  b_rd_busy, n_rd_busy, z_rd_busy;
   logic        b_rsv_ok,  n_rsv_ok,  z_rsv_ok;
   logic [4:0]  b_busy_cnt, n_busy_cnt, z_busy_cnt;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   gpr_file_sb #(.WIDTH(32), .DEPTH(16), .NRD(2), .NWR(2), .ZERO_REG(0), .BYPASS(1)) u_byp (
      .clk(clk), .rst(rst), .i_rd_addr(rd_addr), .o_rd_data(b_rd_data), .o_rd_busy(b_rd_busy),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_rsv_en(rsv_en),
      .i_rsv_addr(rsv_addr), .o_rsv_ok(b_rsv_ok), .i_flush(flush), .o_busy_cnt(b_busy_cnt));

   gpr_file_sb #(.WIDTH(32), .DEPTH(16), .NRD(2), .NWR(2), .ZERO_REG(0), .BYPASS(0)) u_nob (
      .clk(clk), .rst(rst), .i_rd_addr(rd_addr), .o_rd_data(n_rd_data), .o_rd_busy(n_rd_busy),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_rsv_en(rsv_en),
      .i_rsv_addr(rsv_addr), .o_rsv_ok(n_rsv_ok), .i_flush(flush), .o_busy_cnt(n_busy_cnt));

   gpr_file_sb #(.WIDTH(32), .DEPTH(16), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) u_zero (
      .clk(clk), .rst(rst), .i_rd_addr(rd_addr), .o_rd_data(z_rd_data), .o_rd_busy(z_rd_busy),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_rsv_en(rsv_en),
      .i_rsv_addr(rsv_addr), .o_rsv_ok(z_rsv_ok), .i_flush(flush), .o_busy_cnt(z_busy_cnt));

   task automatic idle();
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;
      flush    = 1'b0;
      rd_addr  = '0;
   endtask

   task automatic drive_wr(input int p, input logic [3:0] a, input logic [31:0] d);
      wr_en[p]          = 1'b1;
      wr_addr[p*4 +: 4] = a;
      wr_data[p*32 +: 32] = d;
   endtask

   task automatic test_reset();
      logic [31:0] e0, e1;
      rst = 1'b1;
      idle();
      rsv_en = 1'b1; rsv_addr = 4'd3;
      @(negedge clk); #1;
      checks++;
      if (b_rsv_ok !== 1'b0) begin
         errors++; $display("FAIL reset_rsv_ok got %0b want 0", b_rsv_ok);
      end
      @(negedge clk);
      rst = 1'b0;
      idle();
      for (int r = 0; r < 16; r++) begin
         rd_addr = {4'(15 - r), 4'(r)};
         exp_q.push_back(32'h0); exp_q.push_back(32'h0);
         #1;
         e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
         checks++;
         if (b_rd_data !== {e1, e0} || b_rd_busy !== 2'b00 || b_busy_cnt !== 5'd0) begin
            errors++;
            $display("FAIL reset_read r%0d got data=%h busy=%b cnt=%0d want data=%h busy=0 cnt=0",
                     r, b_rd_data, b_rd_busy, b_busy_cnt, {e1, e0});
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] e;
      idle(); drive_wr(0, 4'd5, 32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
      @(negedge clk);
      idle(); rd_addr = {4'd0, 4'd5}; #1;
      e = exp_q.pop_front();
      checks++;
      if (n_rd_data[31:0] !== e) begin
         errors++; $display("FAIL pre_reset_r5 got %h want %h", n_rd_data[31:0], e);
      end
      drive_wr(0, 4'd6, 32'hCAFEF00D); rsv_en = 1'b1; rsv_addr = 4'd9;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (b_rd_data !== 64'h0 || b_rsv_ok !== 1'b0) begin
         errors++; $display("FAIL in_reset_outputs got data=%h ok=%0b want data=0 ok=0", b_rd_data, b_rsv_ok);
      end
      @(negedge clk);
      rst = 1'b0; idle(); rd_addr = {4'd6, 4'd5}; #1;
      checks++;
      if (n_rd_data !== 64'h0 || n_busy_cnt !== 5'd0) begin
         errors++; $display("FAIL post_reset_r5_r6 got data=%h cnt=%0d want data=0 cnt=0", n_rd_data, n_busy_cnt);
      end
      // reservation in flight must be wiped by an asynchronous reset
      @(negedge clk); idle(); rsv_en = 1'b1; rsv_addr = 4'd3;
      @(negedge clk); idle(); #1;
      checks++;
      if (b_busy_cnt !== 5'd1) begin
         errors++; $display("FAIL busy_before_reset got %0d want 1", b_busy_cnt);
      end
      rst = 1'b1; #1;
      checks++;
      if (b_busy_cnt !== 5'd0) begin
         errors++; $display("FAIL async_reset_busy got %0d want 0", b_busy_cnt);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_write_priority();
      logic [31:0] e, e1;
      idle(); drive_wr(0, 4'd3, 32'h99);
      @(negedge clk);
      idle(); drive_wr(0, 4'd3, 32'h11); drive_wr(1, 4'd3, 32'h22); rd_addr = {4'd0, 4'd3};
      exp_q.push_back(32'h22); exp_q.push_back(32'h99); exp_q.push_back(32'h22);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (b_rd_data[31:0] !== e) begin
         errors++; $display("FAIL bypass_priority got %h want %h", b_rd_data[31:0], e);
      end
      e = exp_q.pop_front();
      checks++;
      if (n_rd_data[31:0] !== e) begin
         errors++; $display("FAIL nobypass_old got %h want %h", n_rd_data[31:0], e);
      end
      e = exp_q.pop_front();
      checks++;
      if (z_rd_data[31:0] !== e) begin
         errors++; $display("FAIL zero_variant_bypass got %h want %h", z_rd_data[31:0], e);
      end
      exp_q.push_back(32'h22);
      @(negedge clk);
      idle(); rd_addr = {4'd0, 4'd3}; #1;
      e = exp_q.pop_front();
      checks++;
      if (n_rd_data[31:0] !== e) begin
         errors++; $display("FAIL write_priority got %h want %h", n_rd_data[31:0], e);
      end
      drive_wr(0, 4'd8, 32'hA0A0); drive_wr(1, 4'd9, 32'hB0B0);
      exp_q.push_back(32'hA0A0); exp_q.push_back(32'hB0B0);
      @(negedge clk);
      idle(); rd_addr = {4'd9, 4'd8}; #1;
      e = exp_q.pop_front(); e1 = exp_q.pop_front();
      checks++;
      if (n_rd_data !== {e1, e}) begin
         errors++; $display("FAIL dual_port_write got %h want %h", n_rd_data, {e1, e});
      end
   endtask

   task automatic test_reserve();
      @(negedge clk); idle(); rsv_en = 1'b1; rsv_addr = 4'd7; #1;
      checks++;
      if (b_rsv_ok !== 1'b1) begin
         errors++; $display("FAIL reserve_r7 got %0b want 1", b_rsv_ok);
      end
      @(negedge clk); idle(); rsv_en = 1'b1; rsv_addr = 4'd7; rd_addr = {4'd0, 4'd7}; #1;
      checks++;
      if (b_rsv_ok !== 1'b0 || b_rd_busy[0] !== 1'b1 || b_busy_cnt !== 5'd1) begin
         errors++; $display("FAIL reserve_again got ok=%0b busy=%0b cnt=%0d want ok=0 busy=1 cnt=1",
                            b_rsv_ok, b_rd_busy[0], b_busy_cnt);
      end
      @(negedge clk); idle(); drive_wr(0, 4'd7, 32'h55); rd_addr = {4'd0, 4'd7}; #1;
      checks++;
      if (b_rd_busy[0] !== 1'b0 || n_rd_busy[0] !== 1'b1 || b_rd_data[31:0] !== 32'h55) begin
         errors++; $display("FAIL writeback_same_cycle got bbusy=%0b nbusy=%0b data=%h want 0 1 00000055",
                            b_rd_busy[0], n_rd_busy[0], b_rd_data[31:0]);
      end
      @(negedge clk); idle(); rd_addr = {4'd0, 4'd7}; #1;
      checks++;
      if (n_rd_busy[0] !== 1'b0 || n_busy_cnt !== 5'd0 || n_rd_data[31:0] !== 32'h55) begin
         errors++; $display("FAIL writeback_release got busy=%0b cnt=%0d data=%h want 0 0 00000055",
                            n_rd_busy[0], n_busy_cnt, n_rd_data[31:0]);
      end
   endtask

   task automatic test_write_reserve_same();
      @(negedge clk); idle(); rsv_en = 1'b1; rsv_addr = 4'd7; #1;
      checks++;
      if (b_rsv_ok !== 1'b1) begin
         errors++; $display("FAIL wrs_first_reserve got %0b want 1", b_rsv_ok);
      end
      @(negedge clk); idle(); rsv_en = 1'b1; rsv_addr = 4'd7; drive_wr(1, 4'd7, 32'h66); #1;
      checks++;
      if (b_rsv_ok !== 1'b0) begin
         errors++; $display("FAIL wrs_busy_reserve got %0b want 0", b_rsv_ok);
      end
      @(negedge clk); idle(); rsv_en = 1'b1; rsv_addr = 4'd7; rd_addr = {4'd0, 4'd7}; #1;
      checks++;
      if (n_rd_busy[0] !== 1'b0 || n_busy_cnt !== 5'd0 || b_rsv_ok !== 1'b1) begin
         errors++; $display("FAIL wrs_retry got busy=%0b cnt=%0d ok=%0b want 0 0 1",
                            n_rd_busy[0], n_busy_cnt, b_rsv_ok);
      end
      @(negedge clk); idle(); rsv_en = 1'b1; rsv_addr = 4'd10; drive_wr(0, 4'd10, 32'h77); #1;
      checks++;
      if (b_rsv_ok !== 1'b1) begin
         errors++; $display("FAIL wrs_free_reserve got %0b want 1", b_rsv_ok);
      end
      @(negedge clk); idle(); rd_addr = {4'd10, 4'd7}; #1;
      checks++;
      if (n_rd_busy !== 2'b11 || n_busy_cnt !== 5'd2 || n_rd_data[63:32] !== 32'h77) begin
         errors++; $display("FAIL wrs_new_owner got busy=%b cnt=%0d data=%h want 11 2 00000077",
                            n_rd_busy, n_busy_cnt, n_rd_data[63:32]);
      end
      @(negedge clk); idle(); drive_wr(0, 4'd7, 32'h70); drive_wr(1, 4'd10, 32'hA0);
      @(negedge clk); idle(); #1;
      checks++;
      if (n_busy_cnt !== 5'd0) begin
         errors++; $display("FAIL wrs_cleanup got %0d want 0", n_busy_cnt);
      end
   endtask

   task automatic test_flush();
      logic [31:0] e0, e1;
      @(negedge clk); idle(); drive_wr(0, 4'd1, 32'h101); drive_wr(1, 4'd2, 32'h202);
      exp_q.push_back(32'h101); exp_q.push_back(32'h202);
      @(negedge clk); idle(); drive_wr(0, 4'd4, 32'h404);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); idle(); rsv_en = 1'b1;
         rsv_addr = (k == 0) ? 4'd1 : (k == 1) ? 4'd2 : 4'd4;
         #1;
         checks++;
         if (b_rsv_ok !== 1'b1) begin
            errors++; $display("FAIL flush_setup_reserve k=%0d got %0b want 1", k, b_rsv_ok);
         end
      end
      @(negedge clk); idle(); #1;
      checks++;
      if (b_busy_cnt !== 5'd3) begin
         errors++; $display("FAIL busy_cnt_three got %0d want 3", b_busy_cnt);
      end
      flush = 1'b1; rsv_en = 1'b1; rsv_addr = 4'd5; drive_wr(0, 4'd6, 32'h606); #1;
      checks++;
      if (b_rsv_ok !== 1'b0) begin
         errors++; $display("FAIL reserve_during_flush got %0b want 0", b_rsv_ok);
      end
      @(negedge clk); idle(); rd_addr = {4'd2, 4'd1}; #1;
      e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
      checks++;
      if (b_busy_cnt !== 5'd0 || n_rd_data !== {e1, e0} || n_rd_busy !== 2'b00) begin
         errors++; $display("FAIL flush_clear got cnt=%0d data=%h busy=%b want 0 %h 00",
                            b_busy_cnt, n_rd_data, n_rd_busy, {e1, e0});
      end
      @(negedge clk); idle(); rd_addr = {4'd6, 4'd4}; #1;
      checks++;
      if (n_rd_data !== {32'h606, 32'h404}) begin
         errors++; $display("FAIL flush_data got %h want %h", n_rd_data, {32'h606, 32'h404});
      end
   endtask

   task automatic test_zero_reg();
      @(negedge clk); idle(); drive_wr(1, 4'd0, 32'hFFFF); #1;
      checks++;
      if (z_rd_data !== 64'h0 || b_rd_data[31:0] !== 32'hFFFF) begin
         errors++; $display("FAIL zero_write_bypass got z=%h b=%h want 0 0000ffff", z_rd_data, b_rd_data[31:0]);
      end
      @(negedge clk); idle(); rsv_en = 1'b1; rsv_addr = 4'd0; #1;
      checks++;
      if (z_rd_data !== 64'h0 || n_rd_data[31:0] !== 32'hFFFF || z_rsv_ok !== 1'b1 || b_rsv_ok !== 1'b1) begin
         errors++; $display("FAIL zero_write_drop got z=%h n=%h zok=%0b bok=%0b want 0 0000ffff 1 1",
                            z_rd_data, n_rd_data[31:0], z_rsv_ok, b_rsv_ok);
      end
      @(negedge clk); idle(); #1;
      checks++;
      if (z_rd_busy !== 2'b00 || z_busy_cnt !== 5'd0 || b_rd_busy !== 2'b11 || b_busy_cnt !== 5'd1) begin
         errors++; $display("FAIL zero_reserve got zbusy=%b zcnt=%0d bbusy=%b bcnt=%0d want 00 0 11 1",
                            z_rd_busy, z_busy_cnt, b_rd_busy, b_busy_cnt);
      end
      flush = 1'b1;
      @(negedge clk); idle();
   endtask

   task automatic test_back_to_back();
      logic [31:0] d, e;
      for (int r = 0; r < 16; r++) begin
         @(negedge clk); idle();
         d = $urandom;
         drive_wr(r % 2, 4'(r), d);
         rsv_en = 1'b1; rsv_addr = 4'(r);
         rd_addr = {4'd0, 4'(r)};
         exp_q.push_back(d);
         #1;
         checks++;
         if (b_rd_data[31:0] !== d || b_rd_busy[0] !== 1'b0 || b_rsv_ok !== 1'b1) begin
            errors++; $display("FAIL b2b_bypass r%0d got data=%h busy=%0b ok=%0b want %h 0 1",
                               r, b_rd_data[31:0], b_rd_busy[0], b_rsv_ok, d);
         end
      end
      @(negedge clk); idle(); #1;
      checks++;
      if (b_busy_cnt !== 5'd16 || z_busy_cnt !== 5'd15) begin
         errors++; $display("FAIL busy_cnt_full got b=%0d z=%0d want 16 15", b_busy_cnt, z_busy_cnt);
      end
      for (int r = 0; r < 16; r++) begin
         @(negedge clk); idle(); rd_addr = {4'(r), 4'(r)}; #1;
         e = exp_q.pop_front();
         checks++;
         if (n_rd_data !== {e, e} || n_rd_busy !== 2'b11) begin
            errors++; $display("FAIL b2b_readback r%0d got data=%h busy=%b want %h 11",
                               r, n_rd_data, n_rd_busy, {e, e});
         end
      end
      @(negedge clk); idle(); flush = 1'b1;
      @(negedge clk); idle(); #1;
      checks++;
      if (b_busy_cnt !== 5'd0 || z_busy_cnt !== 5'd0) begin
         errors++; $display("FAIL b2b_flush got b=%0d z=%0d want 0 0", b_busy_cnt, z_busy_cnt);
      end
   endtask

   initial begin
      rst = 1'b0;
      idle();
      #1 rst = 1'b1;
      test_reset();
      test_reset_mid();
      test_write_priority();
      test_reserve();
      test_write_reserve_same();
      test_flush();
      test_zero_reg();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
